// File: rtl/data_distribution.sv
// data_distribution: byte-to-beat serializer with a one-byte holding register.
// Each accepted word is emitted as NB = DIN_W/DOUT_W consecutive beats, most
// significant beat first, so a downstream shift-in-at-LSB consolidator
// reassembles the original word.
module data_distribution #(
    parameter int DIN_W  = 8,
    parameter int DOUT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_en,
    output logic              din_rdy,
    output logic [DOUT_W-1:0] dout,
    output logic              dout_en,
    output logic              dout_last,
    output logic              ovf
);

    localparam int NB    = DIN_W / DOUT_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             LAST_ON_LOAD = (NB == 1);

    // Most significant beat of a word: the beat that goes out first.
    function automatic logic [DOUT_W-1:0] top_beat(input logic [DIN_W-1:0] w);
        return w[DIN_W-1 -: DOUT_W];
    endfunction

    logic [DIN_W-1:0]  sh_r,  sh_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              busy_r, busy_s;
    logic [DIN_W-1:0]  hold_r, hold_s;
    logic              hold_vld_r, hold_vld_s;
    logic [DOUT_W-1:0] dout_r, dout_s;
    logic              dout_en_r, dout_en_s;
    logic              dout_last_r, dout_last_s;
    logic              ovf_r, ovf_s;
    logic              accept_s;
    logic              last_s;
    logic [DIN_W-1:0]  shifted_s;

    assign accept_s  = din_en && !hold_vld_r;
    assign last_s    = busy_r && (cnt_r == CNT_LAST);
    assign shifted_s = sh_r << DOUT_W;

    // Next-state selection: load, shift, hold capture or go idle.
    always_comb begin
        sh_s        = sh_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        hold_s      = hold_r;
        hold_vld_s  = hold_vld_r;
        dout_s      = {DOUT_W{1'b0}};
        dout_en_s   = 1'b0;
        dout_last_s = 1'b0;
        ovf_s       = ovf_r | (din_en & hold_vld_r);
        if (!busy_r) begin
            if (accept_s) begin
                sh_s        = din;
                cnt_s       = {CNT_W{1'b0}};
                busy_s      = 1'b1;
                dout_s      = top_beat(din);
                dout_en_s   = 1'b1;
                dout_last_s = LAST_ON_LOAD;
            end else begin
                busy_s      = 1'b0;
            end
        end else if (!last_s) begin
            sh_s        = shifted_s;
            cnt_s       = cnt_r + CNT_ONE;
            dout_s      = top_beat(shifted_s);
            dout_en_s   = 1'b1;
            dout_last_s = ((cnt_r + CNT_ONE) == CNT_LAST);
            if (accept_s) begin
                hold_s     = din;
                hold_vld_s = 1'b1;
            end else begin
                hold_vld_s = hold_vld_r;
            end
        end else begin
            // Last beat ends here: held byte has priority over a bypass.
            if (hold_vld_r) begin
                sh_s        = hold_r;
                cnt_s       = {CNT_W{1'b0}};
                hold_vld_s  = 1'b0;
                dout_s      = top_beat(hold_r);
                dout_en_s   = 1'b1;
                dout_last_s = LAST_ON_LOAD;
            end else if (accept_s) begin
                sh_s        = din;
                cnt_s       = {CNT_W{1'b0}};
                dout_s      = top_beat(din);
                dout_en_s   = 1'b1;
                dout_last_s = LAST_ON_LOAD;
            end else begin
                busy_s      = 1'b0;
                cnt_s       = {CNT_W{1'b0}};
            end
        end
    end

    // State and output registers; reset discards any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r        <= {DIN_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            hold_r      <= {DIN_W{1'b0}};
            hold_vld_r  <= 1'b0;
            dout_r      <= {DOUT_W{1'b0}};
            dout_en_r   <= 1'b0;
            dout_last_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            sh_r        <= sh_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            hold_r      <= hold_s;
            hold_vld_r  <= hold_vld_s;
            dout_r      <= dout_s;
            dout_en_r   <= dout_en_s;
            dout_last_r <= dout_last_s;
            ovf_r       <= ovf_s;
        end
    end

    assign din_rdy   = !hold_vld_r;
    assign dout      = dout_r;
    assign dout_en   = dout_en_r;
    assign dout_last = dout_last_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_data_distribution.sv
// Testbench for data_distribution: directed scenarios plus random traffic,
// checked every cycle against a beat-queue reference model.
module tb_data_distribution;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_en;
    logic       din_rdy;
    logic [1:0] dout;
    logic       dout_en;
    logic       dout_last;
    logic       ovf;

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: beats still to be presented (head = beat on dout now).
    logic [1:0] mq[$];
    bit         ml[$];
    logic [7:0] sent[$];
    bit         m_ovf;
    logic [7:0] acc;
    logic [1:0] lg[$];

    data_distribution #(.DIN_W(8), .DOUT_W(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .din_rdy(din_rdy),
        .dout(dout), .dout_en(dout_en), .dout_last(dout_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete(); ml.delete(); sent.delete();
        m_ovf = 1'b0;
        acc = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int v;
        v = b;
        for (int i = 0; i < 4; i++) begin
            mq.push_back(2'((v >> (2 * (3 - i))) % 4));
            ml.push_back(i == 3);
        end
        sent.push_back(b);
    endtask

    task automatic check_outputs();
        chk("din_rdy", din_rdy, (mq.size() <= 4) ? 1 : 0);
        chk("dout_en", dout_en, (mq.size() > 0) ? 1 : 0);
        chk("dout", dout, (mq.size() > 0) ? mq[0] : 2'd0);
        chk("dout_last", dout_last, (mq.size() > 0) ? ml[0] : 1'b0);
        chk("ovf", ovf, m_ovf);
        if (dout_en === 1'b1) begin
            lg.push_back(dout);
            acc = {acc[5:0], dout};
            if (dout_last === 1'b1) begin
                chk("reasm_present", (sent.size() > 0) ? 1 : 0, 1);
                if (sent.size() > 0) chk("reasm", acc, sent.pop_front());
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic en, input logic [7:0] d);
        bit rdy_m;
        din_en = en;
        din    = d;
        rdy_m  = (mq.size() <= 4);
        @(posedge clk);
        if (mq.size() > 0) begin
            void'(mq.pop_front());
            void'(ml.pop_front());
        end
        if (en && rdy_m) push_byte(d);
        if (en && !rdy_m) m_ovf = 1'b1;
        @(negedge clk);
        din_en = 1'b0;
        check_outputs();
    endtask

    task automatic check_log(input string tag, input logic [95:0] exp, input int n);
        chk({tag, "_len"}, lg.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < lg.size()) chk(tag, lg[i], exp[2 * (n - 1 - i) +: 2]);
        end
        lg.delete();
    endtask

    initial begin
        logic [7:0] bp[3];
        int  idx;
        bit  saw_low;
        bit  rdy_m;
        rst = 1'b1; din = 8'h00; din_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        lg.delete();

        // Single byte from idle.
        step(1'b1, 8'hB4);
        repeat (5) step(1'b0, 8'h00);
        check_log("single", 96'hB4, 4);

        // Streaming via bypass path, one byte per 4 cycles.
        step(1'b1, 8'h12); repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h34); repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h56); repeat (5) step(1'b0, 8'h00);
        check_log("stream", 96'h123456, 12);

        // Backpressure: din_en held high, advance only when ready.
        bp[0] = 8'hA5; bp[1] = 8'h3C; bp[2] = 8'hFF;
        idx = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && idx < 3; c++) begin
            rdy_m = (mq.size() <= 4);
            if (din_rdy === 1'b0) saw_low = 1'b1;
            step(1'b1, bp[idx]);
            if (rdy_m) idx++;
        end
        chk("bp_all_accepted", idx, 3);
        chk("bp_rdy_low_seen", saw_low, 1);
        repeat (14) step(1'b0, 8'h00);
        check_log("backpressure", 96'hA53CFF, 12);

        // Overflow: third byte offered while holding register is full.
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        chk("ovf_set", ovf, 1);
        repeat (10) step(1'b0, 8'h00);
        chk("ovf_sticky", ovf, 1);
        check_log("overflow", 96'h1122, 8);

        // Reset mid-byte.
        step(1'b1, 8'hC3);
        step(1'b0, 8'h00);
        rst = 1'b1;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_en", dout_en, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_din_rdy", din_rdy, 1);
        #2;
        rst = 1'b0;
        model_reset();
        lg.delete();
        @(negedge clk);
        check_outputs();
        step(1'b1, 8'h5A);
        repeat (5) step(1'b0, 8'h00);
        check_log("after_rst", 96'h5A, 4);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        repeat (12) step(1'b0, 8'h00);
        chk("rand_drained", sent.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
